layer_output_serializer: RTL and testbench
==========================================

# layer_output_serializer

Collects the activation outputs of every neuron in one ELM layer, each arriving with its own one-cycle `outvalid` pulse, and replays them as a single word-per-cycle stream. That stream drives the shared `myinput`/`myinputValid` bus of the next layer's neurons. During the replay it also tracks the unsigned argmax of the layer, which the final layer uses for the classification result. It sits directly downstream of a layer's neuron array.

## Interface
- `NUM_NEURONS`, 30, number of neurons in the source layer (≥2)
- `IN_WIDTH`, 16, width of one neuron output (activation ROM width)
- `OUT_WIDTH`, 16, width of the emitted word (≥ `IN_WIDTH`; zero-extended)
- `IDX_WIDTH`, derived: max(1, clog2(`NUM_NEURONS`))

- `clk` in 1: sole clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `neuron_out` in `NUM_NEURONS*IN_WIDTH`: packed outputs; neuron k occupies bits [k*IN_WIDTH +: IN_WIDTH]
- `neuron_valid` in `NUM_NEURONS`: bit k = neuron k `outvalid`, one-cycle pulse
- `out_data` out `OUT_WIDTH`: serialized word (drives next layer `myinput`)
- `out_valid` out 1: word valid (drives next layer `myinputValid`)
- `max_idx` out `IDX_WIDTH`: index of largest output of the last completed frame
- `max_val` out `IN_WIDTH`: value at `max_idx`
- `max_valid` out 1: one-cycle pulse, `max_idx`/`max_val` updated
- `busy` out 1: high in SHIFT and REPORT
- `overrun` out 1: sticky error flag

## Operation
- States: CAPTURE (reset state), SHIFT, REPORT.
- CAPTURE
  - For each k with `neuron_valid[k]=1` and capture flag k clear: latch the word into `buf[k]` and set flag k.
  - A valid on an already-set flag: word ignored, `overrun` set.
  - Partial, staggered arrival is legal; multiple bits may be high in one cycle.
  - When the flags including this cycle's captures are all set: go to SHIFT, clear all flags, load shift index 0, initialize max to {idx 0, val 0}.
- SHIFT
  - Each cycle: `out_data` ← zero-extend(`buf[idx]`), `out_valid` ← 1, idx++.
  - Argmax update: replace only if `buf[idx]` > current max (unsigned, strict). Ties keep the lower index.
  - After the word with idx = `NUM_NEURONS`-1 is emitted: go to REPORT.
- REPORT (1 cycle): `max_idx`/`max_val` registered, `max_valid`=1, `out_valid`=0; then go to CAPTURE.
- Any `neuron_valid` bit high in SHIFT or REPORT: ignored, `overrun` set. The current frame is unaffected.
- `overrun` clears only on `rst`.
- `rst` mid-frame:
  - state → CAPTURE, flags cleared, the partial frame is discarded.
  - `out_valid`=0, `max_valid`=0, `busy`=0, `overrun`=0, `out_data`=0, `max_idx`=0, `max_val`=0.
  - `buf` contents are not reset.

## Timing
- All outputs are registered; the reset values are listed above.
- Let the last missing `neuron_valid` be high in cycle t.
  - `out_valid` is high in cycles t+1 … t+`NUM_NEURONS`, contiguous with no gaps. Word k appears in cycle t+1+k.
  - `max_valid` is high in cycle t+`NUM_NEURONS`+1.
  - Capture is re-enabled from cycle t+`NUM_NEURONS`+2.
- `busy` is high in cycles t+1 … t+`NUM_NEURONS`+1.
- No backpressure: downstream neurons must accept one word per cycle.
- Minimum frame period: `NUM_NEURONS`+2 cycles.
- When all neurons fire in the same cycle (the normal case), the frame completes in that one CAPTURE cycle.

## Structure
- Shared package `elm_pkg`: state encoding (CAPTURE/SHIFT/REPORT), the default widths (16) and the default neuron count.
- Sub-module `argmax_tracker`: inputs clear, valid, idx, value; outputs registered max_idx/max_val. Strict-greater compare, unsigned. It is instantiated once.
- Capture buffer is a register array of `NUM_NEURONS` entries plus a flag vector. The read mux is indexed by the shift counter.

## Test plan
1. Simultaneous arrival: `NUM_NEURONS`=4, valid=4'b1111 with outputs {k0=0x0100, 0x0800, 0x0400, 0x0020}.
   - `out_valid` in 4 consecutive cycles: 0x0100, 0x0800, 0x0400, 0x0020.
   - `max_valid` next cycle with `max_idx`=1, `max_val`=0x0800.
2. Staggered arrival: valid 4'b0001, then 4'b0100 two cycles later, then 4'b1010.
   - No `out_valid` until the cycle after 4'b1010.
   - Stream order is index 0..3.
3. Tie: all four outputs 0x0555 → `max_idx`=0. A second tie case with idx2 = idx3 = 0x7FFF as the maximum → `max_idx`=2.
4. Overrun:
   - valid[0] twice before the frame completes → `overrun`=1, first value kept.
   - valid during SHIFT → `overrun`=1 and the stream is unchanged.
5. Reset mid-SHIFT after 2 words → `out_valid` 0 the next cycle, no `max_valid`, `busy`=0, `overrun`=0. A subsequent full frame serializes correctly.
6. Back-to-back frames: the second 4'b1111 arrives exactly at cycle t+6 (`NUM_NEURONS`+2). Both frames stream correctly with no overrun.

Source files
------------

// File: rtl/elm_pkg.sv
// ============================================================================
// elm_pkg : shared state encoding and default sizes for the ELM layer blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package elm_pkg;

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_NUM_NEURONS = 30;

endpackage

`default_nettype wire

// File: rtl/argmax_tracker.sv
// ============================================================================
// argmax_tracker : running unsigned argmax with strict-greater replacement
// Rev 1.0
// ============================================================================
`default_nettype none

module argmax_tracker
    import elm_pkg::*;
#(
    parameter int IDX_WIDTH = 5,
    parameter int VAL_WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic [VAL_WIDTH-1:0] value,
    output logic [IDX_WIDTH-1:0] max_idx,
    output logic [VAL_WIDTH-1:0] max_val
);

    logic [IDX_WIDTH-1:0] w_base_idx;
    logic [VAL_WIDTH-1:0] w_base_val;

    // clear and valid together compare the first sample against {0, 0}
    always_comb begin
        w_base_idx = clear ? '0 : max_idx;
        w_base_val = clear ? '0 : max_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_idx <= '0;
            max_val <= '0;
        end else if (valid && (value > w_base_val)) begin
            max_idx <= idx;
            max_val <= value;
        end else begin
            max_idx <= w_base_idx;
            max_val <= w_base_val;
        end
    end

endmodule

`default_nettype wire

// File: rtl/layer_output_serializer.sv
// ============================================================================
// layer_output_serializer : gathers one layer's neuron outputs and replays
// them as a word-per-cycle stream while tracking the layer argmax
// Rev 1.0
// ============================================================================
`default_nettype none

module layer_output_serializer
    import elm_pkg::*;
#(
    parameter int  NUM_NEURONS = DEFAULT_NUM_NEURONS,
    parameter int  IN_WIDTH    = DEFAULT_WIDTH,
    parameter int  OUT_WIDTH   = DEFAULT_WIDTH,
    localparam int IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]          neuron_valid,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    output logic [IDX_WIDTH-1:0]            max_idx,
    output logic [IN_WIDTH-1:0]             max_val,
    output logic                            max_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int                   CNT_WIDTH = $clog2(NUM_NEURONS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(NUM_NEURONS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [1:0]             r_state;
    logic [NUM_NEURONS-1:0] r_flags;
    logic [IN_WIDTH-1:0]    r_buf [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]   r_idx;

    logic [NUM_NEURONS-1:0] w_cap;
    logic                   w_all;
    logic                   w_dup;
    logic [IDX_WIDTH-1:0]   w_rd_idx;
    logic [IN_WIDTH-1:0]    w_word;
    logic [OUT_WIDTH-1:0]   w_word_ext;
    logic                   w_trk_clear;
    logic                   w_trk_valid;
    logic [IDX_WIDTH-1:0]   w_trk_idx;
    logic [IDX_WIDTH-1:0]   w_trk_max_idx;
    logic [IN_WIDTH-1:0]    w_trk_max_val;

    // r_idx holds the index of the next word to emit; word 0 leaves on the
    // completing capture edge, bypassing the buffer if it arrives that cycle
    always_comb begin
        w_cap      = neuron_valid & ~r_flags;
        w_all      = &(r_flags | w_cap);
        w_dup      = |(neuron_valid & r_flags);
        w_rd_idx   = r_idx[IDX_WIDTH-1:0];
        w_word     = r_buf[w_rd_idx];
        if (r_state == ST_CAPTURE) begin
            w_word = w_cap[0] ? neuron_out[IN_WIDTH-1:0] : r_buf[0];
        end
        w_word_ext = '0;
        w_word_ext[IN_WIDTH-1:0] = w_word;
        w_trk_clear = (r_state == ST_CAPTURE) && w_all;
        w_trk_valid = w_trk_clear || ((r_state == ST_SHIFT) && (r_idx != CNT_LAST));
        w_trk_idx   = (r_state == ST_CAPTURE) ? '0 : w_rd_idx;
    end

    generate
        for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_buf
            always_ff @(posedge clk) begin
                if (!rst && (r_state == ST_CAPTURE) && w_cap[k]) begin
                    r_buf[k] <= neuron_out[k*IN_WIDTH +: IN_WIDTH];
                end
            end
        end
    endgenerate

    argmax_tracker #(
        .IDX_WIDTH (IDX_WIDTH),
        .VAL_WIDTH (IN_WIDTH)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_trk_clear),
        .valid   (w_trk_valid),
        .idx     (w_trk_idx),
        .value   (w_word),
        .max_idx (w_trk_max_idx),
        .max_val (w_trk_max_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CAPTURE;
            r_flags   <= '0;
            r_idx     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            max_idx   <= '0;
            max_val   <= '0;
            max_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            max_valid <= 1'b0;
            case (r_state)
                ST_CAPTURE: begin
                    if (w_dup) begin
                        overrun <= 1'b1;
                    end
                    if (w_all) begin
                        r_flags   <= '0;
                        r_state   <= ST_SHIFT;
                        r_idx     <= CNT_ONE;
                        out_data  <= w_word_ext;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        r_flags <= r_flags | w_cap;
                    end
                end
                ST_SHIFT: begin
                    if (|neuron_valid) begin
                        overrun <= 1'b1;
                    end
                    if (r_idx == CNT_LAST) begin
                        out_valid <= 1'b0;
                        max_valid <= 1'b1;
                        max_idx   <= w_trk_max_idx;
                        max_val   <= w_trk_max_val;
                        r_state   <= ST_REPORT;
                    end else begin
                        out_data <= w_word_ext;
                        r_idx    <= r_idx + CNT_ONE;
                    end
                end
                ST_REPORT: begin
                    if (|neuron_valid) begin
                        overrun <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= ST_CAPTURE;
                end
                default: begin
                    r_state <= ST_CAPTURE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
// ============================================================================
// tb_layer_output_serializer : directed bench with a frame-timeline model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_layer_output_serializer;

    localparam int N  = 4;
    localparam int IW = 16;

    logic          clk;
    logic          rst;
    logic [N*IW-1:0] neuron_out;
    logic [N-1:0]  neuron_valid;
    logic [IW-1:0] out_data;
    logic          out_valid;
    logic [1:0]    max_idx;
    logic [IW-1:0] max_val;
    logic          max_valid;
    logic          busy;
    logic          overrun;

    layer_output_serializer #(
        .NUM_NEURONS (N),
        .IN_WIDTH    (IW),
        .OUT_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .max_idx      (max_idx),
        .max_val      (max_val),
        .max_valid    (max_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: a frame completing in cycle t streams word k in cycle
    // t+1+k, reports in t+N+1, and rejects valids in t+1..t+N+1.
    int            cyc = 0;
    bit            started = 1'b0;
    bit [N-1:0]    m_flags = '0;
    logic [IW-1:0] m_buf   [N];
    logic [IW-1:0] m_frame [N];
    int            m_t = 0;
    bit            m_active = 1'b0;
    bit            m_ovr = 1'b0;
    logic [1:0]    m_best_idx = '0;
    logic [IW-1:0] m_best_val = '0;
    logic [1:0]    m_rep_idx = '0;
    logic [IW-1:0] m_rep_val = '0;

    initial begin
        int c;
        forever begin
            @(posedge clk);
            c = cyc;
            if (rst) begin
                started   = 1'b1;
                m_flags   = '0;
                m_active  = 1'b0;
                m_ovr     = 1'b0;
                m_rep_idx = '0;
                m_rep_val = '0;
            end else begin
                if (m_active && c == m_t + N) begin
                    m_rep_idx = m_best_idx;
                    m_rep_val = m_best_val;
                end
                if (m_active && c >= m_t + 1 && c <= m_t + N + 1) begin
                    if (neuron_valid != '0) m_ovr = 1'b1;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (neuron_valid[k]) begin
                            if (m_flags[k]) m_ovr = 1'b1;
                            else begin
                                m_buf[k]   = neuron_out[k*IW +: IW];
                                m_flags[k] = 1'b1;
                            end
                        end
                    end
                    if (&m_flags) begin
                        m_flags    = '0;
                        m_active   = 1'b1;
                        m_t        = c;
                        m_best_idx = '0;
                        m_best_val = '0;
                        for (int k = 0; k < N; k++) begin
                            m_frame[k] = m_buf[k];
                            if (m_buf[k] > m_best_val) begin
                                m_best_val = m_buf[k];
                                m_best_idx = 2'(k);
                            end
                        end
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    initial begin
        int  d;
        bit  e_ov;
        bit  e_mv;
        bit  e_busy;
        forever begin
            @(negedge clk);
            if (started) begin
                d      = cyc;
                e_ov   = m_active && d >= m_t + 1 && d <= m_t + N;
                e_mv   = m_active && d == m_t + N + 1;
                e_busy = m_active && d >= m_t + 1 && d <= m_t + N + 1;
                chk("out_valid", 32'(out_valid), 32'(e_ov));
                chk("max_valid", 32'(max_valid), 32'(e_mv));
                chk("busy",      32'(busy),      32'(e_busy));
                chk("overrun",   32'(overrun),   32'(m_ovr));
                chk("max_idx",   32'(max_idx),   32'(m_rep_idx));
                chk("max_val",   32'(max_val),   32'(m_rep_val));
                if (e_ov) chk("out_data", 32'(out_data), 32'(m_frame[d - m_t - 1]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // words = {w3, w2, w1, w0}; valid is held for exactly one cycle
    task automatic fire(input logic [N-1:0] v, input logic [N*IW-1:0] words);
        neuron_valid = v;
        neuron_out   = words;
        @(negedge clk);
        neuron_valid = '0;
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        neuron_valid = '0;
        neuron_out   = '0;
        idle(3);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_max_idx",   32'(max_idx),   32'd0);

        // simultaneous arrival
        fire(4'hF, {16'h0020, 16'h0400, 16'h0800, 16'h0100});
        n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("t1_valid_seen", 32'(out_valid), 32'd1);
        chk("t1_w0", 32'(out_data), 32'h0100);
        idle(1); chk("t1_w1", 32'(out_data), 32'h0800);
        idle(1); chk("t1_w2", 32'(out_data), 32'h0400);
        idle(1); chk("t1_w3", 32'(out_data), 32'h0020);
        idle(1);
        chk("t1_max_valid", 32'(max_valid), 32'd1);
        chk("t1_max_idx",   32'(max_idx),   32'd1);
        chk("t1_max_val",   32'(max_val),   32'h0800);
        idle(4);

        // staggered arrival
        fire(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0011});
        idle(1);
        fire(4'b0100, {16'h0000, 16'h0033, 16'h0000, 16'h0000});
        chk("t2_no_early", 32'(out_valid), 32'd0);
        fire(4'b1010, {16'h0044, 16'h0000, 16'h0022, 16'h0000});
        chk("t2_w0", 32'(out_data), 32'h0011);
        idle(4);
        chk("t2_max_idx", 32'(max_idx), 32'd3);
        idle(2);

        // ties
        fire(4'hF, {16'h0555, 16'h0555, 16'h0555, 16'h0555});
        idle(4);
        chk("t3_tie_idx", 32'(max_idx), 32'd0);
        chk("t3_tie_val", 32'(max_val), 32'h0555);
        idle(1);
        fire(4'hF, {16'h7FFF, 16'h7FFF, 16'h0002, 16'h0001});
        idle(4);
        chk("t3_tie2_idx", 32'(max_idx), 32'd2);
        idle(1);

        // back-to-back frames at the minimum period
        fire(4'hF, {16'h0001, 16'h2000, 16'h0FFF, 16'h1000});
        idle(4);
        chk("t6_f1_idx", 32'(max_idx), 32'd2);
        idle(1);
        fire(4'hF, {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF});
        chk("t6_f2_w0", 32'(out_data), 32'hFFFF);
        idle(4);
        chk("t6_f2_idx", 32'(max_idx), 32'd0);
        chk("t6_no_ovr", 32'(overrun), 32'd0);
        idle(2);

        // overrun: duplicate capture, then valids during SHIFT
        fire(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h1111});
        fire(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h2222});
        fire(4'b1110, {16'h0005, 16'h0004, 16'h0003, 16'h0000});
        chk("t4_first_kept", 32'(out_data), 32'h1111);
        chk("t4_ovr", 32'(overrun), 32'd1);
        fire(4'hF, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        chk("t4_stream_kept", 32'(out_data), 32'h0003);
        idle(5);

        // reset in the middle of SHIFT
        fire(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_busy",      32'(busy),      32'd0);
        chk("t5_overrun",   32'(overrun),   32'd0);
        chk("t5_max_valid", 32'(max_valid), 32'd0);
        idle(6);
        fire(4'hF, {16'h000A, 16'h000D, 16'h000B, 16'h000C});
        chk("t5_post_w0", 32'(out_data), 32'h000C);
        idle(4);
        chk("t5_post_idx", 32'(max_idx), 32'd2);
        chk("t5_post_val", 32'(max_val), 32'h000D);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
